// File: rtl/uart_pkg.sv
// Shared UART definitions: frame levels, tx FSM states, parity mode encoding.
package uart_pkg;

    localparam int DATA_BITS = 8;

    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_mode_e;

    function automatic parity_mode_e parity_mode(input logic en, input logic odd);
        if (!en)
            return PAR_NONE;
        return odd ? PAR_ODD : PAR_EVEN;
    endfunction

    // Bit that makes the total count of ones even (PAR_EVEN) or odd (PAR_ODD).
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d, input parity_mode_e m);
        return (^d) ^ (m == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Byte handshake into the buffered transmitter.
// Master drives tx_data/tx_valid; the transmitter returns tx_ready.
interface uart_tx_buffered_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with show-ahead read data and occupancy count.
// Latency: pushed word visible at pop_dat_o one clk after the push edge.
// Backpressure: push ignored when full, pop ignored when empty.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_dat_o,
    output logic [CW-1:0]    count_o,
    output logic [CW-1:0]    count_nxt_o,
    output logic             full_o,
    output logic             empty_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o   = (count_q == CW'(DEPTH));
    assign empty_o  = (count_q == '0);
    assign do_push  = push_i && !full_o;
    assign do_pop   = pop_i && !empty_o;
    assign count_d  = count_q + CW'(do_push) - CW'(do_pop);

    assign pop_dat_o   = mem_q[rd_ptr_q];
    assign count_o     = count_q;
    assign count_nxt_o = count_d;

    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[wr_ptr_q] <= push_dat_i;
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1/8E1/8O1 UART transmitter, LSB first, one bit per baud_tick.
// Latency: push into idle block -> start bit one clk after the next baud_tick.
// Backpressure: tx_ready low while FIFO full; pushes when full are dropped.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int STOP_BITS = 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       baud_tick,
    uart_tx_buffered_if.slave          s_if,
    input  logic                       parity_en,
    input  logic                       parity_odd,
    output logic                       tx,
    output logic                       tx_busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);
    localparam int CW = $clog2(DEPTH + 1);

    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    parity_mode_e         mode_q, mode_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;

    logic                 pop;
    logic [DATA_BITS-1:0] head;
    logic [CW-1:0]        count_nxt;
    logic                 full, empty;

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (s_if.tx_valid),
        .push_dat_i  (s_if.tx_data),
        .pop_i       (pop),
        .pop_dat_o   (head),
        .count_o     (fifo_count),
        .count_nxt_o (count_nxt),
        .full_o      (full),
        .empty_o     (empty)
    );

    assign s_if.tx_ready = !full;
    assign tx            = tx_q;
    assign tx_busy       = busy_q;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        mode_d     = mode_q;
        par_d      = par_q;
        tx_d       = tx_q;
        pop        = 1'b0;

        if (baud_tick) begin
            case (state_q)
                TX_IDLE: pop = !empty;
                TX_START: begin
                    state_d   = TX_DATA;
                    tx_d      = shift_q[0];
                    bit_cnt_d = '0;
                end
                TX_DATA: begin
                    if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
                        stop_cnt_d = 1'b0;
                        if (mode_q != PAR_NONE) begin
                            state_d = TX_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = TX_STOP;
                            tx_d    = STOP_LVL;
                        end
                    end else begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                TX_PARITY: begin
                    state_d    = TX_STOP;
                    tx_d       = STOP_LVL;
                    stop_cnt_d = 1'b0;
                end
                TX_STOP: begin
                    if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                        pop = !empty;
                        if (empty)
                            state_d = TX_IDLE;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
                default: state_d = TX_IDLE;
            endcase
        end

        // Frame start: parity settings are frozen here for the whole frame.
        if (pop) begin
            state_d = TX_START;
            shift_d = head;
            mode_d  = parity_mode(parity_en, parity_odd);
            par_d   = parity_bit(head, mode_d);
            tx_d    = START_LVL;
        end

        busy_d = (state_d != TX_IDLE) || (count_nxt != '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= TX_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            mode_q     <= PAR_NONE;
            par_q      <= 1'b0;
            tx_q       <= IDLE_LVL;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            mode_q     <= mode_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: one-stop-bit and two-stop-bit instances, frame-level reference model.
module tb_uart_tx_buffered;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic baud_tick = 1'b0;
    logic parity_en = 1'b0;
    logic parity_odd = 1'b0;

    always #5 clk = ~clk;

    uart_tx_buffered_if a_if ();
    uart_tx_buffered_if b_if ();

    logic       tx_a, busy_a, tx_b, busy_b;
    logic [2:0] cnt_a, cnt_b;

    uart_tx_buffered #(.DEPTH(4), .STOP_BITS(1)) dut (
        .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick), .s_if(a_if),
        .parity_en(parity_en), .parity_odd(parity_odd),
        .tx(tx_a), .tx_busy(busy_a), .fifo_count(cnt_a)
    );

    uart_tx_buffered #(.DEPTH(4), .STOP_BITS(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick), .s_if(b_if),
        .parity_en(parity_en), .parity_odd(parity_odd),
        .tx(tx_b), .tx_busy(busy_b), .fifo_count(cnt_b)
    );

    int n_assert = 0;
    int n_fail = 0;
    bit exp_a[$];
    bit exp_b[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference frame: start, 8 data bits LSB first, optional parity, stop bits.
    task automatic add_frame(input bit sel, input logic [7:0] b, input bit en, input bit odd,
                             input int stops);
        bit q[$];
        int ones = 0;
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            q.push_back(b[i]);
            ones += int'(b[i]);
        end
        if (en)
            q.push_back(odd ? (ones % 2 == 0) : (ones % 2 == 1));
        for (int i = 0; i < stops; i++)
            q.push_back(1'b1);
        foreach (q[i]) begin
            if (sel) exp_b.push_back(q[i]);
            else     exp_a.push_back(q[i]);
        end
    endtask

    // One baud period per bit; the line is sampled mid-period.
    task automatic run_bits(input int n, input string tag);
        bit ea, eb;
        for (int i = 0; i < n; i++) begin
            @(negedge clk) baud_tick = 1'b1;
            @(negedge clk) baud_tick = 1'b0;
            repeat (7) @(negedge clk);
            ea = (exp_a.size() != 0) ? exp_a.pop_front() : 1'b1;
            eb = (exp_b.size() != 0) ? exp_b.pop_front() : 1'b1;
            chk({tag, "_tx_a"}, 32'(tx_a), 32'(ea));
            chk({tag, "_tx_b"}, 32'(tx_b), 32'(eb));
            repeat (7) @(negedge clk);
        end
    endtask

    task automatic push(input bit sel, input logic [7:0] b, output bit acc);
        @(negedge clk);
        if (sel) begin
            b_if.tx_data = b; b_if.tx_valid = 1'b1; acc = b_if.tx_ready;
        end else begin
            a_if.tx_data = b; a_if.tx_valid = 1'b1; acc = a_if.tx_ready;
        end
    endtask

    task automatic release_bus();
        @(negedge clk);
        a_if.tx_valid = 1'b0;
        b_if.tx_valid = 1'b0;
    endtask

    initial begin
        bit          acc;
        logic [7:0]  rb;
        logic [7:0]  burst [3];
        bit          ren, rodd;

        a_if.tx_data = '0; a_if.tx_valid = 1'b0;
        b_if.tx_data = '0; b_if.tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx_a), 32'd1);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_ready", 32'(a_if.tx_ready), 32'd1);
        chk("rst_count", 32'(cnt_a), 32'd0);
        chk("rst_tx_b", 32'(tx_b), 32'd1);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        run_bits(2, "idle");

        // Single 8N1 frame
        push(1'b0, 8'hA5, acc);
        release_bus();
        chk("a5_count", 32'(cnt_a), 32'd1);
        chk("a5_busy", 32'(busy_a), 32'd1);
        add_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1);
        run_bits(10, "a5");
        chk("a5_count_end", 32'(cnt_a), 32'd0);
        chk("a5_busy_in_stop", 32'(busy_a), 32'd1);
        run_bits(1, "a5_tail");
        chk("a5_busy_end", 32'(busy_a), 32'd0);

        // Even then odd parity
        for (int p = 0; p < 2; p++) begin
            parity_en = 1'b1;
            parity_odd = p[0];
            push(1'b0, 8'hA5, acc);
            push(1'b0, 8'hD5, acc);
            release_bus();
            add_frame(1'b0, 8'hA5, 1'b1, p[0], 1);
            add_frame(1'b0, 8'hD5, 1'b1, p[0], 1);
            run_bits(23, "par");
            chk("par_busy_end", 32'(busy_a), 32'd0);
        end
        parity_en = 1'b0;

        // Three pushes on consecutive clks, frames back-to-back
        push(1'b0, 8'hA5, acc);
        push(1'b0, 8'hC3, acc);
        push(1'b0, 8'hD5, acc);
        release_bus();
        chk("b2b_count_peak", 32'(cnt_a), 32'd3);
        add_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1);
        add_frame(1'b0, 8'hC3, 1'b0, 1'b0, 1);
        add_frame(1'b0, 8'hD5, 1'b0, 1'b0, 1);
        run_bits(1, "b2b");
        chk("b2b_count_pop", 32'(cnt_a), 32'd2);
        run_bits(30, "b2b");
        chk("b2b_busy_end", 32'(busy_a), 32'd0);

        // Fill with ticks stalled; bytes 5 and 6 are refused
        for (int i = 1; i <= 6; i++) begin
            push(1'b0, 8'(i), acc);
            chk("full_accept", 32'(acc), (i <= 4) ? 32'd1 : 32'd0);
        end
        release_bus();
        chk("full_count", 32'(cnt_a), 32'd4);
        chk("full_ready", 32'(a_if.tx_ready), 32'd0);
        for (int i = 1; i <= 4; i++)
            add_frame(1'b0, 8'(i), 1'b0, 1'b0, 1);
        run_bits(41, "full");
        chk("full_busy_end", 32'(busy_a), 32'd0);
        chk("full_count_end", 32'(cnt_a), 32'd0);

        // Push in the same clk as the pop: count stays at 1
        push(1'b0, 8'h3C, acc);
        release_bus();
        @(negedge clk);
        baud_tick = 1'b1; a_if.tx_data = 8'h96; a_if.tx_valid = 1'b1;
        @(negedge clk);
        baud_tick = 1'b0; a_if.tx_valid = 1'b0;
        chk("pushpop_count", 32'(cnt_a), 32'd1);
        add_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1);
        add_frame(1'b0, 8'h96, 1'b0, 1'b0, 1);
        repeat (7) @(negedge clk);
        chk("pushpop_start", 32'(tx_a), 32'(exp_a.pop_front()));
        repeat (7) @(negedge clk);
        run_bits(20, "pushpop");
        chk("pushpop_busy_end", 32'(busy_a), 32'd0);

        // Random frames; parity inputs scrambled after the frame has started
        for (int k = 0; k < 6; k++) begin
            rb = 8'($urandom);
            ren = 1'($urandom_range(0, 1));
            rodd = 1'($urandom_range(0, 1));
            parity_en = ren;
            parity_odd = rodd;
            push(1'b0, rb, acc);
            release_bus();
            add_frame(1'b0, rb, ren, rodd, 1);
            run_bits(1, "rnd");
            parity_en = 1'($urandom_range(0, 1));
            parity_odd = 1'($urandom_range(0, 1));
            run_bits(ren ? 11 : 10, "rnd");
            chk("rnd_busy_end", 32'(busy_a), 32'd0);
        end

        // Random back-to-back burst
        ren = 1'($urandom_range(0, 1));
        rodd = 1'($urandom_range(0, 1));
        parity_en = ren;
        parity_odd = rodd;
        for (int k = 0; k < 3; k++) begin
            burst[k] = 8'($urandom);
            push(1'b0, burst[k], acc);
            add_frame(1'b0, burst[k], ren, rodd, 1);
        end
        release_bus();
        run_bits(ren ? 34 : 31, "burst");
        chk("burst_busy_end", 32'(busy_a), 32'd0);
        parity_en = 1'b0;

        // Reset during data bit 3 of 0xC3 with another byte queued
        push(1'b0, 8'hC3, acc);
        push(1'b0, 8'h77, acc);
        release_bus();
        add_frame(1'b0, 8'hC3, 1'b0, 1'b0, 1);
        run_bits(4, "rst_mid");
        @(negedge clk) baud_tick = 1'b1;
        @(negedge clk) baud_tick = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid_bit3", 32'(tx_a), 32'd0);
        chk("rst_mid_count", 32'(cnt_a), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_async_tx", 32'(tx_a), 32'd1);
        chk("rst_async_busy", 32'(busy_a), 32'd0);
        chk("rst_async_count", 32'(cnt_a), 32'd0);
        chk("rst_async_ready", 32'(a_if.tx_ready), 32'd1);
        exp_a.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        run_bits(12, "post_rst");
        chk("post_rst_busy", 32'(busy_a), 32'd0);

        // Two stop bits with a second byte already queued
        push(1'b1, 8'h55, acc);
        push(1'b1, 8'h0F, acc);
        release_bus();
        chk("stop2_count", 32'(cnt_b), 32'd2);
        add_frame(1'b1, 8'h55, 1'b0, 1'b0, 2);
        add_frame(1'b1, 8'h0F, 1'b0, 1'b0, 2);
        run_bits(23, "stop2");
        chk("stop2_busy_end", 32'(busy_b), 32'd0);
        chk("stop2_count_end", 32'(cnt_b), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
- Buffered UART transmitter; the transmit-direction counterpart of the UART receive path inside uart_top.
- Accepts bytes over a valid/ready handshake into a small FIFO.
- Serialises each byte LSB-first on tx as an 8N1/8E1/8O1 frame, one bit per baud_tick from the shared baud generator.
- Sits beside the receiver in uart_top and shares its clk, reset_n and baud tick.

Parameters:
- DEPTH, 4: FIFO depth in bytes; power of two, minimum 2.
- STOP_BITS, 1: number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- baud_tick  input  1  one-clk pulse per bit period, from baud generator
- tx_data  input  8  byte to transmit
- tx_valid  input  1  tx_data is valid
- tx_ready  output  1  FIFO can accept a byte
- parity_en  input  1  1 = append parity bit
- parity_odd  input  1  1 = odd parity, 0 = even parity
- tx  output  1  serial line, idle high
- tx_busy  output  1  frame in progress or FIFO non-empty
- fifo_count  output  $clog2(DEPTH+1)  bytes currently held in the FIFO

Behaviour:
- Reset (async, reset_n=0):
  - tx=1, tx_busy=0, tx_ready=1, fifo_count=0.
  - FSM goes to IDLE, FIFO pointers clear.
  - Reset mid-frame aborts the frame; tx returns to 1 immediately, with no clock needed.
- Push:
  - A byte is written on the rising clk edge where tx_valid && tx_ready.
  - tx_ready = (fifo_count != DEPTH), driven from registered state.
  - Pushes while full are ignored and the byte is lost. The upstream must hold tx_valid.
- FSM states: IDLE, START, DATA, PARITY, STOP. All transitions occur only on clk edges where baud_tick=1.
  - IDLE -> START when the FIFO is non-empty.
    - Pops the head into shift_reg.
    - Latches parity_en/parity_odd for the whole frame.
    - tx=0 registered.
  - START -> DATA: tx = shift_reg[0], bit_cnt=0.
  - DATA: each tick shifts right and increments bit_cnt; tx follows shift_reg[0].
    - After bit 7's tick, goes to PARITY if the latched parity_en, else STOP.
  - PARITY: tx = ^byte XOR latched parity_odd, giving an even or odd count of ones including the parity bit.
  - STOP: tx=1 for STOP_BITS tick periods, then
    - to START if the FIFO is non-empty (pop and tx=0 back-to-back, no idle bit), or
    - to IDLE otherwise.
- Timing:
  - Each bit lasts exactly one baud_tick period.
  - tx is a flop output and changes one clk after the qualifying tick.
  - Latency from a push into an empty, idle block to the tx falling edge = next baud_tick + 1 clk.
- tx_busy = (state != IDLE) || (fifo_count != 0), registered-equivalent and glitch-free.
- Simultaneous push and pop in the same clk: both take effect and fifo_count is unchanged. When full, tx_ready is already 0, so the push is refused even if a pop occurs that cycle.
- FIFO pointers wrap modulo DEPTH; fifo_count is never greater than DEPTH.
- parity_en/parity_odd changes mid-frame do not affect the current frame.
- Back-to-back baud_tick on consecutive clks is legal; the FSM advances once per tick.

Decomposition:
- Shared package uart_pkg:
  - tx FSM state enum.
  - DATA_BITS=8.
  - Frame constants: START_LVL=0, STOP_LVL=1, IDLE_LVL=1.
  - Parity mode encoding, reused by the receiver's parity checker.
- One natural sub-module: uart_sync_fifo (parameterised width/depth, push/pop, count, full/empty).
- FSM, shift register and parity stay in uart_tx_buffered.

Test Plan:
- Idle and tick setup: reset, then baud_tick every 16 clks (generator at baud_rate=3'b110). Push 0xA5 with parity_en=0 -> tx bits per tick are 0,1,0,1,0,0,1,0,1,1. tx_busy falls after the stop bit; fifo_count returns to 0.
- Parity: push 0xA5 then 0xD5 with parity_en=1, parity_odd=0 -> parity bits are 0 for 0xA5 and 1 for 0xD5. Repeat with parity_odd=1 -> parity bits are 1 and 0.
- Back-to-back frames: push 0xA5, 0xC3, 0xD5 in 3 consecutive clks -> fifo_count peaks at 3 (2 after the first pop). The three frames go out with no idle bits between stop and start; the 0xC3 data bits are 1,1,0,0,0,0,1,1.
- Full FIFO: with DEPTH=4 and ticks stalled, push 6 bytes 0x01..0x06 -> tx_ready=0 after 4 are accepted, fifo_count=4, 0x05 and 0x06 are dropped. Resume ticks -> 0x01..0x04 are transmitted in order.
- Reset mid-frame: assert reset_n=0 during the DATA bit 3 of 0xC3 -> tx=1 with no clk edge, fifo_count=0, tx_busy=0. After release, no residual frame is emitted.
- STOP_BITS=2: push 0x55 -> stop level is held for 2 tick periods before the next start bit, with a second byte already queued.
